// File: rtl/ch_buf_pkg.sv
// Shared constants and helpers for the DMA <-> LZS channel buffer.
// Byte-swap functions and the level/threshold compares used by both FIFOs.
package ch_buf_pkg;

  localparam int LANE_W = 32;
  // Widest data path word_bswap() can handle; real DW is passed in.
  localparam int MAX_DW = 1024;

  function automatic int flag_bit(input int dw);
    return dw;
  endfunction

  function automatic logic [LANE_W-1:0] lane_bswap(input logic [LANE_W-1:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Reverse the low dw/8 bytes of x; bytes above dw are returned as zero.
  function automatic logic [MAX_DW-1:0] word_bswap(input logic [MAX_DW-1:0] x, input int dw);
    logic [MAX_DW-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DW/8; i++)
      if (i < dw/8) r[8*i +: 8] = x[8*(dw/8-1-i) +: 8];
    return r;
  endfunction

  function automatic logic lvl_ge(input int unsigned lvl, input int unsigned th);
    return lvl >= th;
  endfunction

  function automatic logic lvl_le(input int unsigned lvl, input int unsigned th);
    return lvl <= th;
  endfunction

endpackage

// File: rtl/ch_buf_fifo.sv
// First-word-fall-through sync FIFO with guarded push/pop and occupancy flags.
// Rejected pushes (full) and pops (empty) are flagged for the caller's statistics.
module ch_buf_fifo
  import ch_buf_pkg::*;
#(
  parameter int W     = 65,
  parameter int AW    = 9,
  parameter int AE_TH = 1,
  parameter int AF_TH = 1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic          full,
  output logic          almost_empty,
  output logic          almost_full,
  output logic [AW:0]   level,
  output logic          rej_push,
  output logic          rej_pop
);

  localparam int DEPTH = 2**AW;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign level    = wr_ptr - rd_ptr;
  assign empty    = (level == '0);
  assign full     = (level == (AW+1)'(DEPTH));
  // A full push is dropped even if a pop frees a slot this cycle, and vice versa.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rej_push = push && full;
  assign rej_pop  = pop && empty;

  assign almost_empty = lvl_le(32'(level), AE_TH);
  assign almost_full  = lvl_ge(32'(level), DEPTH - AF_TH);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Head reads zero while empty so outputs are clean out of reset.
  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ch_buf.sv
// Channel buffer between the DMA engine (wb side) and the LZS unit (m_ side).
// Define CH_BUF_STAT_EN to drive live levels and sticky ovf/udf statistics.
module ch_buf
  import ch_buf_pkg::*;
#(
  parameter int DW       = 64,
  parameter int AW       = 9,
  parameter int SRC_STOP = 256,
  parameter int DST_STOP = 16,
  parameter int AE_TH    = 1,
  parameter int AF_TH    = 1,
  parameter bit SWAP     = 1'b1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          m_reset,
  input  logic          src_xfer,
  input  logic          src_last,
  input  logic [DW-1:0] src_dat_o,
  output logic          src_stop,
  output logic          src_start,
  input  logic          m_src_getn,
  output logic [DW-1:0] m_src,
  output logic          m_src_last,
  output logic          m_src_empty,
  output logic          m_src_almost_empty,
  input  logic          m_dst_putn,
  input  logic [DW-1:0] m_dst,
  input  logic          m_dst_last,
  output logic          m_dst_full,
  output logic          m_dst_almost_full,
  input  logic          m_endn,
  input  logic          dst_xfer,
  output logic [DW-1:0] dst_dat_i,
  output logic          dst_end,
  output logic          dst_stop,
  output logic          dst_start,
  output logic [15:0]   ocnt,
  output logic [AW:0]   src_level,
  output logic [AW:0]   dst_level,
  output logic          stat_ovf,
  output logic          stat_udf
);

  localparam int FB = flag_bit(DW);
  localparam int NL = DW / LANE_W;

  logic [DW-1:0] src_wdat, dst_wdat;
  logic [DW:0]   src_head, dst_head;
  logic [AW:0]   src_lvl, dst_lvl;
  logic          src_empty, src_full, src_ae, src_af, src_rej_push, src_rej_pop;
  logic          dst_empty, dst_full, dst_ae, dst_af, dst_rej_push, dst_rej_pop;
  logic          dst_pop;

  generate
    if (SWAP) begin : g_swap
      for (genvar k = 0; k < NL; k++) begin : g_lane
        assign src_wdat[k*LANE_W +: LANE_W] = lane_bswap(src_dat_o[k*LANE_W +: LANE_W]);
      end
      assign dst_wdat = DW'(word_bswap(MAX_DW'(m_dst), DW));
    end else begin : g_pass
      assign src_wdat = src_dat_o;
      assign dst_wdat = m_dst;
    end
  endgenerate

  ch_buf_fifo #(.W(DW+1), .AW(AW), .AE_TH(AE_TH), .AF_TH(AF_TH)) u_src (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .clr          (m_reset),
    .push         (src_xfer),
    .pop          (!m_src_getn),
    .din          ({src_last, src_wdat}),
    .head         (src_head),
    .empty        (src_empty),
    .full         (src_full),
    .almost_empty (src_ae),
    .almost_full  (src_af),
    .level        (src_lvl),
    .rej_push     (src_rej_push),
    .rej_pop      (src_rej_pop)
  );

  ch_buf_fifo #(.W(DW+1), .AW(AW), .AE_TH(AE_TH), .AF_TH(AF_TH)) u_dst (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .clr          (m_reset),
    .push         (!m_dst_putn),
    .pop          (dst_pop),
    .din          ({m_dst_last, dst_wdat}),
    .head         (dst_head),
    .empty        (dst_empty),
    .full         (dst_full),
    .almost_empty (dst_ae),
    .almost_full  (dst_af),
    .level        (dst_lvl),
    .rej_push     (dst_rej_push),
    .rej_pop      (dst_rej_pop)
  );

  assign m_src              = src_head[DW-1:0];
  assign m_src_last         = src_head[FB];
  assign m_src_empty        = src_empty;
  assign m_src_almost_empty = src_ae;
  assign src_start          = !src_af;
  assign src_stop           = lvl_ge(32'(src_lvl), SRC_STOP);

  assign m_dst_full         = dst_full;
  assign m_dst_almost_full  = dst_af;
  assign dst_dat_i          = dst_head[DW-1:0];
  assign dst_end            = !dst_empty && dst_head[FB];
  // End marker parks at the head until m_reset; DMA reads against it are not pops.
  assign dst_pop            = dst_xfer && !dst_end;
  assign dst_stop           = lvl_ge(32'(dst_lvl), DST_STOP);
  assign dst_start          = dst_stop || (!m_endn && !dst_empty);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      ocnt <= '0;
    else if (m_reset)
      ocnt <= '0;
    else if (!m_dst_putn && !m_dst_last && !dst_full && (ocnt != 16'hFFFF))
      ocnt <= ocnt + 16'd1;
  end

`ifdef CH_BUF_STAT_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      stat_ovf <= 1'b0;
      stat_udf <= 1'b0;
    end else if (m_reset) begin
      stat_ovf <= 1'b0;
      stat_udf <= 1'b0;
    end else begin
      if (src_rej_push || dst_rej_push) stat_ovf <= 1'b1;
      if (src_rej_pop  || dst_rej_pop)  stat_udf <= 1'b1;
    end
  end
  assign src_level = src_lvl;
  assign dst_level = dst_lvl;
`else
  assign stat_ovf  = 1'b0;
  assign stat_udf  = 1'b0;
  assign src_level = '0;
  assign dst_level = '0;
`endif

endmodule

// File: tb/tb_ch_buf.sv
// Scoreboard bench for ch_buf: stimulus queues expected heads, a negedge monitor
// compares every word the consumer actually takes; flags are checked directly.
module tb_ch_buf;

  localparam int DW = 64;
  localparam int AW = 9;
`ifdef CH_BUF_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b0;
  logic          m_reset = 1'b0;
  logic          src_xfer = 1'b0, src_last = 1'b0;
  logic [DW-1:0] src_dat_o = '0;
  logic          src_stop, src_start;
  logic          m_src_getn = 1'b1;
  logic [DW-1:0] m_src;
  logic          m_src_last, m_src_empty, m_src_almost_empty;
  logic          m_dst_putn = 1'b1;
  logic [DW-1:0] m_dst = '0;
  logic          m_dst_last = 1'b0;
  logic          m_dst_full, m_dst_almost_full;
  logic          m_endn = 1'b1;
  logic          dst_xfer = 1'b0;
  logic [DW-1:0] dst_dat_i;
  logic          dst_end, dst_stop, dst_start;
  logic [15:0]   ocnt;
  logic [AW:0]   src_level, dst_level;
  logic          stat_ovf, stat_udf;

  int n_chk = 0, n_pass = 0;
  bit mon_en = 1'b1;
  bit [DW:0] sq[$];
  bit [DW:0] dq[$];

  ch_buf dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .m_reset(m_reset),
    .src_xfer(src_xfer), .src_last(src_last), .src_dat_o(src_dat_o),
    .src_stop(src_stop), .src_start(src_start), .m_src_getn(m_src_getn),
    .m_src(m_src), .m_src_last(m_src_last), .m_src_empty(m_src_empty),
    .m_src_almost_empty(m_src_almost_empty), .m_dst_putn(m_dst_putn),
    .m_dst(m_dst), .m_dst_last(m_dst_last), .m_dst_full(m_dst_full),
    .m_dst_almost_full(m_dst_almost_full), .m_endn(m_endn), .dst_xfer(dst_xfer),
    .dst_dat_i(dst_dat_i), .dst_end(dst_end), .dst_stop(dst_stop),
    .dst_start(dst_start), .ocnt(ocnt), .src_level(src_level),
    .dst_level(dst_level), .stat_ovf(stat_ovf), .stat_udf(stat_udf)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  function automatic bit [63:0] sw_lane(input bit [63:0] d);
    bit [31:0] a, b;
    a = {<<8{d[63:32]}};
    b = {<<8{d[31:0]}};
    return {a, b};
  endfunction

  function automatic bit [63:0] sw_word(input bit [63:0] d);
    bit [63:0] r;
    r = {<<8{d}};
    return r;
  endfunction

  // Monitor: compares each word at the moment the consumer pops it.
  always @(negedge wb_clk_i) begin
    bit [DW:0] e;
    if (mon_en && !wb_rst_i && !m_reset) begin
      if (!m_src_getn && !m_src_empty) begin
        if (sq.size() == 0) begin
          n_chk++;
          $display("FAIL src_unexpected: got %h want none", m_src);
        end else begin
          e = sq.pop_front();
          chk("src_data", m_src, e[63:0]);
          chk("src_last", m_src_last, 64'(e[DW]));
        end
      end
      if (dst_xfer && !dst_end) begin
        if (dq.size() == 0) begin
          n_chk++;
          $display("FAIL dst_unexpected: got %h want none", dst_dat_i);
        end else begin
          e = dq.pop_front();
          chk("dst_data", dst_dat_i, e[63:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge wb_clk_i); #1;
  endtask

  task automatic src_push(input bit [63:0] d, input bit l);
    src_xfer = 1'b1; src_dat_o = d; src_last = l;
    sq.push_back({l, sw_lane(d)});
    tick();
    src_xfer = 1'b0; src_last = 1'b0;
  endtask

  task automatic dst_push(input bit [63:0] d, input bit l, input bit track);
    m_dst_putn = 1'b0; m_dst = d; m_dst_last = l;
    if (track) dq.push_back({l, sw_word(d)});
    tick();
    m_dst_putn = 1'b1; m_dst_last = 1'b0;
  endtask

  task automatic mreset;
    m_reset = 1'b1;
    tick();
    m_reset = 1'b0;
  endtask

  initial begin
    // Power-on reset
    #1 wb_rst_i = 1'b1;
    #2;
    chk("rst_src_empty", m_src_empty, 1);
    chk("rst_src_ae", m_src_almost_empty, 1);
    chk("rst_src_start", src_start, 1);
    chk("rst_src_stop", src_stop, 0);
    chk("rst_m_src", m_src, 0);
    chk("rst_dst_dat", dst_dat_i, 0);
    chk("rst_dst_start", dst_start, 0);
    chk("rst_dst_afull", m_dst_almost_full, 0);
    chk("rst_ocnt", ocnt, 0);
    tick(); tick();
    wb_rst_i = 1'b0;
    tick();

    // Asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) src_push(64'hA0A0_0000_0B0B_0000 + 64'(i), 1'b0);
    dst_push(64'h1, 1'b0, 1'b0);
    dst_push(64'h2, 1'b0, 1'b0);
    chk("pre_rst_ocnt", ocnt, 2);
    chk("pre_rst_level", src_level, STAT ? 64'd5 : 64'd0);
    wb_rst_i = 1'b1;
    #1;
    chk("arst_src_empty", m_src_empty, 1);
    chk("arst_ocnt", ocnt, 0);
    chk("arst_src_start", src_start, 1);
    chk("arst_src_level", src_level, 0);
    chk("arst_dst_level", dst_level, 0);
    sq.delete(); dq.delete();
    tick();
    wb_rst_i = 1'b0;
    tick();

    // Src lane swap, FWFT latency, pop to empty
    src_push(64'h44332211_88776655, 1'b0);
    chk("swap_head", m_src, 64'h11223344_55667788);
    chk("swap_not_empty", m_src_empty, 0);
    chk("swap_ae", m_src_almost_empty, 1);
    m_src_getn = 1'b0; tick(); m_src_getn = 1'b1;
    chk("swap_pop_empty", m_src_empty, 1);

    // Pop while empty
    m_src_getn = 1'b0; tick(); m_src_getn = 1'b1;
    chk("udf_sticky", stat_udf, 64'(STAT));
    chk("udf_no_ovf", stat_ovf, 0);
    chk("udf_still_empty", m_src_empty, 1);
    mreset();
    chk("udf_cleared", stat_udf, 0);

    // Fill src to 512, thresholds on the way
    for (int i = 0; i < 512; i++) begin
      src_push({16'hA5A5, 16'(i), 16'h5A5A, 16'(i ^ 255)}, i[0]);
      if (i == 0)   chk("ae_at_1", m_src_almost_empty, 1);
      if (i == 1)   chk("ae_at_2", m_src_almost_empty, 0);
      if (i == 254) chk("stop_at_255", src_stop, 0);
      if (i == 255) chk("stop_at_256", src_stop, 1);
      if (i == 509) chk("start_at_510", src_start, 1);
      if (i == 510) chk("start_at_511", src_start, 0);
    end
    chk("full_level", src_level, STAT ? 64'd512 : 64'd0);
    // Push + pop while full: push must be dropped
    src_xfer = 1'b1; src_dat_o = 64'hDEAD_BEEF_DEAD_BEEF; m_src_getn = 1'b0;
    tick();
    src_xfer = 1'b0; m_src_getn = 1'b1;
    chk("full_pp_level", src_level, STAT ? 64'd511 : 64'd0);
    chk("full_pp_ovf", stat_ovf, 64'(STAT));
    chk("full_pp_start", src_start, 0);
    m_src_getn = 1'b0; repeat (511) tick(); m_src_getn = 1'b1;
    chk("full_drained", m_src_empty, 1);
    chk("full_sb_empty", sq.size(), 0);
    chk("full_no_udf", stat_udf, 0);
    mreset();
    chk("ovf_cleared", stat_ovf, 0);

    // Dst end marker
    for (int i = 0; i < 3; i++) dst_push(64'h1111_2222_3333_0000 + 64'(i), 1'b0, 1'b1);
    dst_push(64'h01234567_89ABCDEF, 1'b1, 1'b0);
    chk("end_not_yet", dst_end, 0);
    dst_xfer = 1'b1; repeat (5) tick(); dst_xfer = 1'b0;
    chk("end_held", dst_end, 1);
    chk("end_data", dst_dat_i, 64'hEFCDAB89_67452301);
    chk("end_ocnt", ocnt, 3);
    chk("end_no_udf", stat_udf, 0);
    chk("end_level", dst_level, STAT ? 64'd1 : 64'd0);
    chk("end_sb_empty", dq.size(), 0);
    mreset();
    chk("end_cleared", dst_end, 0);
    chk("end_ocnt_clr", ocnt, 0);

    // Dst thresholds and m_endn
    for (int i = 0; i < 15; i++) dst_push(64'hC0DE_0000_0000_0000 + 64'(i << 8), 1'b0, 1'b1);
    chk("dstop_at_15", dst_stop, 0);
    chk("dstart_at_15", dst_start, 0);
    dst_push(64'hC0DE_0000_0000_FFFF, 1'b0, 1'b1);
    chk("dstop_at_16", dst_stop, 1);
    chk("dstart_at_16", dst_start, 1);
    chk("thr_ocnt", ocnt, 16);
    dst_xfer = 1'b1; repeat (15) tick(); dst_xfer = 1'b0;
    chk("dstop_at_1", dst_stop, 0);
    chk("dstart_endn_hi", dst_start, 0);
    m_endn = 1'b0; #1;
    chk("dstart_endn_lo", dst_start, 1);
    dst_xfer = 1'b1; tick(); dst_xfer = 1'b0;
    chk("dstart_empty", dst_start, 0);
    m_endn = 1'b1;
    chk("thr_sb_empty", dq.size(), 0);

    // ocnt saturation (push+pop each cycle keeps the FIFO shallow)
    mreset();
    mon_en = 1'b0;
    m_dst = '0; m_dst_putn = 1'b0; dst_xfer = 1'b1;
    repeat (65534) tick();
    m_dst_putn = 1'b1; dst_xfer = 1'b0;
    chk("sat_fffe", ocnt, 16'hFFFE);
    m_dst_putn = 1'b0; repeat (3) tick(); m_dst_putn = 1'b1;
    chk("sat_ffff", ocnt, 16'hFFFF);
    chk("sat_level", dst_level, STAT ? 64'd4 : 64'd0);
    mreset();
    chk("sat_clr", ocnt, 0);

    // m_reset overrides a same-cycle push
    m_reset = 1'b1; src_xfer = 1'b1; src_dat_o = 64'h5;
    tick();
    m_reset = 1'b0; src_xfer = 1'b0;
    chk("mrst_override", m_src_empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
